universal_shift_register: RTL and testbench

Parametrised successor to the fixed 8-bit parallel register: a WIDTH-bit register with asynchronous clear and a start/busy/done handshake. Supports parallel load, clear, logical/arithmetic shifts and rotates by a programmable amount. It sits between datapath producers and consumers wherever a value must be held, serialised (via `so`) or realigned, and replaces ad-hoc banks of `_dff` instances.

---
 rtl/usr_pkg.sv | 34 +++
 rtl/usr_shift_unit.sv | 70 +++++++
 rtl/universal_shift_register.sv | 114 +++++++++++
 tb/tb_universal_shift_register.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// Shared definitions for universal_shift_register: op encodings, FSM state
// encoding and op-class predicates.
package usr_pkg;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_CLEAR = 3'b010;
  localparam logic [2:0] OP_SHL   = 3'b011;
  localparam logic [2:0] OP_SHR   = 3'b100;
  localparam logic [2:0] OP_ROL   = 3'b101;
  localparam logic [2:0] OP_ROR   = 3'b110;
  localparam logic [2:0] OP_ASR   = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  // Left-type ops shift data out of the MSB, so serial-out taps q[WIDTH-1].
  function automatic logic is_left_op(input logic [2:0] op);
    case (op)
      OP_SHL:  return 1'b1;
      OP_ROL:  return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_shift_op(input logic [2:0] op);
    case (op)
      OP_SHL, OP_SHR, OP_ROL, OP_ROR, OP_ASR: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/usr_shift_unit.sv
// Combinational next-value generator for universal_shift_register.
// UNIVERSAL_SHIFT_REGISTER_BARREL_EN selects a full-amount barrel network over single-bit steps.
module usr_shift_unit
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic [WIDTH-1:0] q,
  input  logic [2:0]       op,
  input  logic             si,
  input  logic [WIDTH-1:0] d,
  input  logic [AMT_W-1:0] amt,
  output logic [WIDTH-1:0] nxt
);

  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
  localparam logic [AMT_W-1:0] ZERO_A = {AMT_W{1'b0}};

`ifdef UNIVERSAL_SHIFT_REGISTER_BARREL_EN
  localparam logic [WIDTH-1:0] ONES_W = {WIDTH{1'b1}};

  logic [31:0]        rot_s;
  logic [2*WIDTH-1:0] dbl_l_s;
  logic [2*WIDTH-1:0] dbl_r_s;

  // Rotates only need amt mod WIDTH; the doubled word turns them into plain shifts.
  always_comb begin
    rot_s   = 32'(amt) % 32'(WIDTH);
    dbl_l_s = {q, q} << rot_s;
    dbl_r_s = {q, q} >> rot_s;
  end

  // Full-amount result; vacated logical-shift bits are filled with si.
  always_comb begin
    nxt = q;
    case (op)
      OP_NOP:   nxt = q;
      OP_LOAD:  nxt = d;
      OP_CLEAR: nxt = ZERO_W;
      OP_SHL:   nxt = (q << amt) | (si ? ~(ONES_W << amt) : ZERO_W);
      OP_SHR:   nxt = (q >> amt) | (si ? ~(ONES_W >> amt) : ZERO_W);
      OP_ROL:   nxt = dbl_l_s[2*WIDTH-1:WIDTH];
      OP_ROR:   nxt = dbl_r_s[WIDTH-1:0];
      OP_ASR:   nxt = $unsigned($signed(q) >>> amt);
      default:  nxt = q;
    endcase
  end
`else
  logic hold_s;

  // A zero amount leaves q untouched; otherwise one single-bit step.
  always_comb begin
    hold_s = (amt == ZERO_A);
    nxt    = q;
    case (op)
      OP_NOP:   nxt = q;
      OP_LOAD:  nxt = d;
      OP_CLEAR: nxt = ZERO_W;
      OP_SHL:   nxt = hold_s ? q : {q[WIDTH-2:0], si};
      OP_SHR:   nxt = hold_s ? q : {si, q[WIDTH-1:1]};
      OP_ROL:   nxt = hold_s ? q : {q[WIDTH-2:0], q[WIDTH-1]};
      OP_ROR:   nxt = hold_s ? q : {q[0], q[WIDTH-1:1]};
      OP_ASR:   nxt = hold_s ? q : {q[WIDTH-1], q[WIDTH-1:1]};
      default:  nxt = q;
    endcase
  end
`endif

endmodule

// File: rtl/universal_shift_register.sv
// WIDTH-bit universal shift register with start/busy/done handshake.
// Define UNIVERSAL_SHIFT_REGISTER_BARREL_EN for single-cycle barrel shifts.
module universal_shift_register
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [AMT_W-1:0] amt,
  input  logic             si,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             so,
  output logic             busy,
  output logic             done
);

  localparam logic [AMT_W-1:0] ONE_A  = {{(AMT_W-1){1'b0}}, 1'b1};
  localparam logic [AMT_W-1:0] ZERO_A = {AMT_W{1'b0}};

  logic [1:0]       state_r;
  logic [2:0]       op_r;
  logic [AMT_W-1:0] cnt_r;
  logic [WIDTH-1:0] q_r;
  logic             busy_r;
  logic             done_r;

  logic             accept_s;
  logic             multi_s;
  logic [2:0]       op_sel_s;
  logic [AMT_W-1:0] amt_sel_s;
  logic [WIDTH-1:0] nxt_s;

  // In RUN the remaining count (always >= 1) keeps the shift unit stepping.
  always_comb begin
    accept_s = start && (state_r != ST_RUN);
    if (accept_s) begin
      op_sel_s  = op;
      amt_sel_s = amt;
    end else begin
      op_sel_s  = op_r;
      amt_sel_s = cnt_r;
    end
`ifdef UNIVERSAL_SHIFT_REGISTER_BARREL_EN
    multi_s = 1'b0;
`else
    multi_s = is_shift_op(op) && (amt > ONE_A);
`endif
  end

  usr_shift_unit #(
    .WIDTH(WIDTH),
    .AMT_W(AMT_W)
  ) u_shift (
    .q   (q_r),
    .op  (op_sel_s),
    .si  (si),
    .d   (d),
    .amt (amt_sel_s),
    .nxt (nxt_s)
  );

  // FSM, step counter and data register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      op_r    <= OP_NOP;
      cnt_r   <= ZERO_A;
      q_r     <= {WIDTH{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else if (accept_s) begin
      op_r <= op;
      q_r  <= nxt_s;
      if (multi_s) begin
        state_r <= ST_RUN;
        cnt_r   <= amt - ONE_A;
        busy_r  <= 1'b1;
        done_r  <= 1'b0;
      end else begin
        state_r <= ST_DONE;
        cnt_r   <= ZERO_A;
        busy_r  <= 1'b0;
        done_r  <= 1'b1;
      end
    end else if (state_r == ST_RUN) begin
      q_r   <= nxt_s;
      cnt_r <= cnt_r - ONE_A;
      if (cnt_r == ONE_A) begin
        state_r <= ST_DONE;
        busy_r  <= 1'b0;
        done_r  <= 1'b1;
      end else begin
        state_r <= ST_RUN;
        busy_r  <= 1'b1;
        done_r  <= 1'b0;
      end
    end else begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end
  end

  assign q    = q_r;
  assign busy = busy_r;
  assign done = done_r;
  assign so   = is_left_op(op_r) ? q_r[WIDTH-1] : q_r[0];

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed self-checking bench for universal_shift_register (serial build).
module tb_universal_shift_register;
  import usr_pkg::*;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [2:0] op;
  logic [2:0] amt;
  logic       si;
  logic [7:0] d;
  logic [7:0] q;
  logic       so;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;

  universal_shift_register #(.WIDTH(8), .AMT_W(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .amt     (amt),
    .si      (si),
    .d       (d),
    .q       (q),
    .so      (so),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare q/busy/done in one go.
  task automatic check_st(input string tag, input logic [7:0] eq, input logic eb, input logic ed);
    check({tag, ".q"}, 32'(q), 32'(eq));
    check({tag, ".busy"}, 32'(busy), 32'(eb));
    check({tag, ".done"}, 32'(done), 32'(ed));
  endtask

  task automatic issue(input logic [2:0] o, input logic [2:0] a, input logic [7:0] dv, input logic s);
    start = 1'b1;
    op    = o;
    amt   = a;
    d     = dv;
    si    = s;
  endtask

  initial begin
    reset_n = 1'b0;
    issue(OP_LOAD, 3'd0, 8'hFF, 1'b1);
    repeat (3) @(negedge clk);
    check_st("reset", 8'h00, 1'b0, 1'b0);
    check("reset.so", 32'(so), 32'd0);
    start   = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    check_st("idle", 8'h00, 1'b0, 1'b0);

    // LOAD 0xA5
    issue(OP_LOAD, 3'd0, 8'hA5, 1'b0);
    @(negedge clk); start = 1'b0;
    check_st("load_e0", 8'hA5, 1'b0, 1'b1);
    @(negedge clk);
    check_st("load_after", 8'hA5, 1'b0, 1'b0);

    // ROL amt=3: 0x4B, 0x96, 0x2D
    issue(OP_ROL, 3'd3, 8'h00, 1'b1);
    @(negedge clk); start = 1'b0;
    check_st("rol_e0", 8'h4B, 1'b1, 1'b0);
    check("rol_e0.so", 32'(so), 32'd0);
    @(negedge clk);
    check_st("rol_e1", 8'h96, 1'b1, 1'b0);
    check("rol_e1.so", 32'(so), 32'd1);
    @(negedge clk);
    check_st("rol_e2", 8'h2D, 1'b0, 1'b1);
    @(negedge clk);
    check_st("rol_idle", 8'h2D, 1'b0, 1'b0);

    // LOAD 0x96 then ASR amt=2 with si=0: 0xCB, 0xE5
    issue(OP_LOAD, 3'd0, 8'h96, 1'b0);
    @(negedge clk);
    issue(OP_ASR, 3'd2, 8'h00, 1'b0);
    @(negedge clk); start = 1'b0;
    check_st("asr_e0", 8'hCB, 1'b1, 1'b0);
    @(negedge clk);
    check_st("asr_e1", 8'hE5, 1'b0, 1'b1);
    check("asr.so", 32'(so), 32'd1);

    // Back-to-back SHR amt=0 issued in the DONE cycle
    issue(OP_SHR, 3'd0, 8'h00, 1'b1);
    @(negedge clk); start = 1'b0;
    check_st("shr0_b2b", 8'hE5, 1'b0, 1'b1);
    @(negedge clk);
    check_st("shr0_idle", 8'hE5, 1'b0, 1'b0);

    // SHL amt=4 si=1 from 0x01 with an ignored LOAD during RUN
    issue(OP_LOAD, 3'd0, 8'h01, 1'b0);
    @(negedge clk);
    issue(OP_SHL, 3'd4, 8'h00, 1'b1);
    @(negedge clk);
    check_st("shl_e0", 8'h03, 1'b1, 1'b0);
    issue(OP_LOAD, 3'd0, 8'hFF, 1'b1);
    @(negedge clk); start = 1'b0;
    check_st("shl_e1", 8'h07, 1'b1, 1'b0);
    @(negedge clk);
    check_st("shl_e2", 8'h0F, 1'b1, 1'b0);
    check("shl_e2.so", 32'(so), 32'd0);
    @(negedge clk);
    check_st("shl_e3", 8'h1F, 1'b0, 1'b1);

    // Back-to-back ROR amt=1 from the DONE cycle: 0x1F -> 0x8F
    issue(OP_ROR, 3'd1, 8'h00, 1'b0);
    @(negedge clk); start = 1'b0;
    check_st("ror_b2b", 8'h8F, 1'b0, 1'b1);
    check("ror.so", 32'(so), 32'd1);
    @(negedge clk);

    // CLEAR then SHR amt=3 with si=1 from 0: 0x80, 0xC0, 0xE0
    issue(OP_CLEAR, 3'd0, 8'h00, 1'b0);
    @(negedge clk);
    check_st("clear", 8'h00, 1'b0, 1'b1);
    issue(OP_SHR, 3'd3, 8'h00, 1'b1);
    @(negedge clk); start = 1'b0;
    check_st("shr_e0", 8'h80, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check_st("shr_e2", 8'hE0, 1'b0, 1'b1);

    // Reset mid-RUN aborts asynchronously
    issue(OP_LOAD, 3'd0, 8'h3C, 1'b0);
    @(negedge clk);
    issue(OP_SHR, 3'd5, 8'h00, 1'b0);
    @(negedge clk); start = 1'b0;
    check_st("abort_pre", 8'h1E, 1'b1, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    check_st("abort_async", 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    issue(OP_LOAD, 3'd0, 8'h77, 1'b0);
    @(negedge clk); start = 1'b0;
    check_st("post_abort_load", 8'h77, 1'b0, 1'b1);
    @(negedge clk);
    check_st("post_abort_idle", 8'h77, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
